spi_boot_loader: RTL and testbench

Post-reset loader that fills the boot memory's writable words from an external SPI flash before the CPU runs. It sits directly upstream of the 16-word boot memory: it issues a flash READ (0x03) sequence as an SPI master, assembles 16-bit words, and writes them through the boot memory's cs/we/addr/din port. It holds the CPU off until the copy completes.

---
 rtl/spi_boot_loader.sv | 168 ++++++++++++++++
 tb/tb_spi_boot_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_boot_loader.sv
// spi_boot_loader: copies words from an SPI flash (READ 0x03) into the
// boot memory after reset, holding the CPU until the copy completes.
module spi_boot_loader #(
  parameter logic [3:0]  START_ADDR = 4'h7,
  parameter int          WORD_COUNT = 5,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          SPI_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bypass,
  input  logic        start,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        cpu_hold,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, CMD, READ, WRITE, FINISH, DONE
  } state_t;

  localparam logic [7:0]  DIV_M1   = 8'(SPI_DIV - 1);
  localparam logic [4:0]  WC       = 5'(WORD_COUNT);
  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};

  state_t       state_q;
  logic [7:0]   div_q;
  logic [5:0]   cnt_q;
  logic [4:0]   idx_q;
  logic [31:0]  cmd_q;
  logic [15:0]  rx_q;
  logic         sclk_q;
  logic         cs_n_q;
  logic         mosi_q;
  logic         done_q;
  logic         hold_q;
  logic         reload_q;
  logic         mcs_q;
  logic         mwe_q;
  logic [3:0]   maddr_q;
  logic [15:0]  mdin_q;
  logic         tick;
  logic [4:0]   idx_d;

  assign tick  = (div_q == DIV_M1);
  assign idx_d = idx_q + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      cmd_q    <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= 1'b1;
      reload_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          div_q <= DIV_M1;
          cnt_q <= '0;
          idx_q <= '0;
          if (bypass && !reload_q) begin
            state_q <= FINISH;
          end else begin
            cs_n_q  <= 1'b0;
            mosi_q  <= CMD_WORD[31];
            cmd_q   <= {CMD_WORD[30:0], 1'b0};
            state_q <= CMD;
          end
        end
        CMD, READ: begin
          if (!tick) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= '0;
            // falls shift mosi; cmd_q is all zero once the command is out
            if (sclk_q) begin
              sclk_q <= 1'b0;
              cnt_q  <= cnt_q + 6'd1;
              mosi_q <= cmd_q[31];
              cmd_q  <= {cmd_q[30:0], 1'b0};
            end else if (state_q == READ && cnt_q == 6'd16) begin
              state_q <= WRITE;
            end else begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[14:0], spi_miso};
              if (state_q == CMD && cnt_q == 6'd32) begin
                state_q <= READ;
                cnt_q   <= '0;
              end
            end
          end
        end
        WRITE: begin
          idx_q <= idx_d;
          if (idx_d == WC) begin
            cs_n_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[14:0], spi_miso};
            div_q   <= '0;
            cnt_q   <= '0;
            state_q <= READ;
          end
        end
        FINISH: begin
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          done_q  <= 1'b1;
          hold_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          if (start) begin
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            idx_q    <= '0;
            reload_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write port launched on the falling edge for the gated memory clock
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      mcs_q   <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
    end else begin
      mcs_q <= (state_q == WRITE);
      mwe_q <= (state_q == WRITE);
      if (state_q == WRITE) begin
        maddr_q <= START_ADDR + idx_q[3:0];
        mdin_q  <= rx_q;
      end
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
  assign mem_cs   = mcs_q;
  assign mem_we   = mwe_q;
  assign mem_addr = maddr_q;
  assign mem_din  = mdin_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader: directed bench with SPI flash and boot memory models
// around a default loader and a wrapped, fast-clocked loader.
module tb_spi_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  localparam logic [15:0] D1 [0:4] = '{16'h1234, 16'hABCD, 16'h0008, 16'hFFFF, 16'h5A5A};
  localparam logic [15:0] D2 [0:4] = '{16'h0F0F, 16'h8001, 16'h1357, 16'h2468, 16'hC3C3};
  localparam logic [15:0] D3 [0:4] = '{16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000, 16'h7E7E};
  localparam logic [15:0] D4 [0:2] = '{16'hA5A5, 16'h0102, 16'hF00D};

  logic        rst0, bypass0, start0, miso0;
  logic        sclk0, cs_n0, mosi0, mcs0, mwe0, hold0, done0;
  logic [3:0]  maddr0;
  logic [15:0] mdin0;

  logic        rst1, bypass1, start1, miso1;
  logic        sclk1, cs_n1, mosi1, mcs1, mwe1, hold1, done1;
  logic [3:0]  maddr1;
  logic [15:0] mdin1;

  spi_boot_loader u0 (
    .clk(clk), .rst(rst0), .bypass(bypass0), .start(start0),
    .spi_miso(miso0), .spi_sclk(sclk0), .spi_cs_n(cs_n0),
    .spi_mosi(mosi0), .mem_cs(mcs0), .mem_we(mwe0),
    .mem_addr(maddr0), .mem_din(mdin0), .cpu_hold(hold0),
    .done(done0)
  );

  spi_boot_loader #(
    .START_ADDR(4'hE), .WORD_COUNT(3),
    .FLASH_BASE(24'h012345), .SPI_DIV(1)
  ) u1 (
    .clk(clk), .rst(rst1), .bypass(bypass1), .start(start1),
    .spi_miso(miso1), .spi_sclk(sclk1), .spi_cs_n(cs_n1),
    .spi_mosi(mosi1), .mem_cs(mcs1), .mem_we(mwe1),
    .mem_addr(maddr1), .mem_din(mdin1), .cpu_hold(hold1),
    .done(done1)
  );

  // flash model 0
  logic [15:0] fd0 [0:15];
  int          rc0 = 0;
  int          b0;
  logic [31:0] cmd0 = '0;
  int          sr0 = 0;
  int          csl0 = 0;

  always @(posedge sclk0 or posedge cs_n0) begin
    if (cs_n0) begin
      rc0 <= 0;
    end else begin
      if (rc0 == 0) cmd0 <= {31'b0, mosi0};
      else if (rc0 < 32) cmd0 <= {cmd0[30:0], mosi0};
      rc0 <= rc0 + 1;
    end
  end

  always @(negedge sclk0 or posedge cs_n0) begin
    if (cs_n0) begin
      miso0 <= 1'b0;
    end else if (rc0 >= 32) begin
      b0 = rc0 - 32;
      miso0 <= fd0[(b0 / 16) % 16][15 - (b0 % 16)];
    end
  end

  always @(posedge sclk0) sr0 <= sr0 + 1;
  always @(negedge cs_n0) csl0 <= csl0 + 1;

  // boot memory model 0
  logic [15:0] mem0 [0:15];
  int          wc0 = 0;
  int          viol0 = 0;

  always @(posedge clk) begin
    if (mcs0 && mwe0) begin
      mem0[maddr0] <= mdin0;
      wc0 <= wc0 + 1;
    end
    if (mcs0 !== mwe0) viol0 <= viol0 + 1;
  end

  // flash model 1
  logic [15:0] fd1 [0:15];
  int          rc1 = 0;
  int          b1;
  logic [31:0] cmd1 = '0;

  always @(posedge sclk1 or posedge cs_n1) begin
    if (cs_n1) begin
      rc1 <= 0;
    end else begin
      if (rc1 == 0) cmd1 <= {31'b0, mosi1};
      else if (rc1 < 32) cmd1 <= {cmd1[30:0], mosi1};
      rc1 <= rc1 + 1;
    end
  end

  always @(negedge sclk1 or posedge cs_n1) begin
    if (cs_n1) begin
      miso1 <= 1'b0;
    end else if (rc1 >= 32) begin
      b1 = rc1 - 32;
      miso1 <= fd1[(b1 / 16) % 16][15 - (b1 % 16)];
    end
  end

  // boot memory model 1
  logic [15:0] mem1 [0:15];
  logic [3:0]  alog1 [0:7];
  int          wc1 = 0;
  int          viol1 = 0;

  always @(posedge clk) begin
    if (mcs1 && mwe1) begin
      mem1[maddr1] <= mdin1;
      alog1[wc1 % 8] <= maddr1;
      wc1 <= wc1 + 1;
    end
    if (mcs1 !== mwe1) viol1 <= viol1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (((sel == 0) ? done0 : done1) !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  int c, s, l, w;

  initial begin
    rst0 = 1'b0; bypass0 = 1'b0; start0 = 1'b0;
    rst1 = 1'b0; bypass1 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fd0[i] = '0;
      fd1[i] = '0;
    end
    for (int i = 0; i < 5; i++) fd0[i] = D1[i];
    for (int i = 0; i < 3; i++) fd1[i] = D4[i];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", {31'b0, cs_n0}, 32'd1);
    chk("rst_sclk", {31'b0, sclk0}, 32'd0);
    chk("rst_mosi", {31'b0, mosi0}, 32'd0);
    chk("rst_mem_cs", {31'b0, mcs0}, 32'd0);
    chk("rst_mem_we", {31'b0, mwe0}, 32'd0);
    chk("rst_mem_addr", {28'b0, maddr0}, 32'd0);
    chk("rst_mem_din", {16'b0, mdin0}, 32'd0);
    chk("rst_done", {31'b0, done0}, 32'd0);
    chk("rst_cpu_hold", {31'b0, hold0}, 32'd1);

    // default load, with a start pulse during CMD
    @(negedge clk);
    rst0 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("cmd_cs_low", {31'b0, cs_n0}, 32'd0);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done(0, c);
    chk("load_latency", c + 21, 32'd456);
    chk("load_cpu_hold", {31'b0, hold0}, 32'd0);
    chk("load_cs_n", {31'b0, cs_n0}, 32'd1);
    chk("load_cmd", cmd0, 32'h03000000);
    chk("load_writes", wc0, 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("load_mem%0d", 7 + i), {16'b0, mem0[7 + i]}, {16'b0, D1[i]});

    // bypass at reset release
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    chk("async_done", {31'b0, done0}, 32'd0);
    chk("async_hold", {31'b0, hold0}, 32'd1);
    bypass0 = 1'b1;
    s = sr0; l = csl0; w = wc0;
    @(negedge clk);
    rst0 = 1'b1;
    wait_done(0, c);
    chk("byp_latency", c, 32'd2);
    chk("byp_hold", {31'b0, hold0}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("byp_sclk_edges", sr0, s);
    chk("byp_cs_low", csl0, l);
    chk("byp_writes", wc0, w);

    // start in DONE reloads even with bypass still high
    for (int i = 0; i < 5; i++) fd0[i] = D2[i];
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("start_hold", {31'b0, hold0}, 32'd1);
    chk("start_done", {31'b0, done0}, 32'd0);
    wait_done(0, c);
    chk("start_latency", c, 32'd456);
    chk("start_writes", wc0, w + 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("start_mem%0d", 7 + i), {16'b0, mem0[7 + i]}, {16'b0, D2[i]});

    // reset during the third word, then full reload
    w = wc0;
    for (int i = 0; i < 5; i++) fd0[i] = D3[i];
    bypass0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    c = 0;
    while (wc0 < w + 2 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("mid_two_writes", wc0, w + 2);
    repeat (10) @(posedge clk);
    #3;
    rst0 = 1'b0;
    #1;
    chk("mid_cs_n", {31'b0, cs_n0}, 32'd1);
    chk("mid_hold", {31'b0, hold0}, 32'd1);
    chk("mid_sclk", {31'b0, sclk0}, 32'd0);
    chk("mid_mem_we", {31'b0, mwe0}, 32'd0);
    chk("mid_mem7", {16'b0, mem0[7]}, {16'b0, D3[0]});
    chk("mid_mem9_kept", {16'b0, mem0[9]}, {16'b0, D2[2]});
    @(negedge clk);
    rst0 = 1'b1;
    wait_done(0, c);
    chk("mid_latency", c, 32'd456);
    chk("mid_writes", wc0, w + 7);
    for (int i = 0; i < 5; i++)
      chk($sformatf("mid_mem%0d", 7 + i), {16'b0, mem0[7 + i]}, {16'b0, D3[i]});
    chk("viol0", viol0, 32'd0);

    // wrapped load, non-zero flash base, SPI_DIV=1
    @(negedge clk);
    rst1 = 1'b1;
    wait_done(1, c);
    chk("wrap_latency", c, 32'd166);
    chk("wrap_hold", {31'b0, hold1}, 32'd0);
    chk("wrap_cmd", cmd1, 32'h03012345);
    chk("wrap_writes", wc1, 32'd3);
    chk("wrap_addr0", {28'b0, alog1[0]}, 32'hE);
    chk("wrap_addr1", {28'b0, alog1[1]}, 32'hF);
    chk("wrap_addr2", {28'b0, alog1[2]}, 32'h0);
    chk("wrap_memE", {16'b0, mem1[14]}, {16'b0, D4[0]});
    chk("wrap_memF", {16'b0, mem1[15]}, {16'b0, D4[1]});
    chk("wrap_mem0", {16'b0, mem1[0]}, {16'b0, D4[2]});
    chk("viol1", viol1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
